// File: rtl/amux_spi_ctrl_pkg.sv
// Shared frame geometry, register map constants and frame FSM encoding.
// No logic and no latency; SPI has no backpressure, so none applies here.
package amux_spi_pkg;

    localparam int          FRAME_W     = 16;
    localparam int          ADDR_W      = 7;
    localparam logic [6:0]  ID_ADDR     = 7'h7F;
    localparam logic [7:0]  CHIP_ID_DEF = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } frame_st_e;

endpackage

// File: rtl/amux_spi_ctrl_if.sv
// SPI slave pins; master drives ss/sck/mosi, the controller drives miso.
// Pure wiring, zero latency; SPI has no flow control.
interface amux_spi_ctrl_if;

    logic ss;
    logic sck;
    logic mosi;
    logic miso;

    modport master (output ss, output sck, output mosi, input miso);
    modport slave  (input ss, input sck, input mosi, output miso);

endinterface

// File: rtl/amux_spi_ctrl_sync.sv
// 2-FF synchroniser with rise/fall pulses, 3 clk from pin to pulse.
// No backpressure; pulses are single-cycle and must be consumed when seen.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic       s1_q;
    logic       s2_q;
    logic       prev_q;
    logic [1:0] prime_q;

    // Edges are held off until the chain has flushed its reset value, so a pin
    // already sitting at the active level at reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= RST_VAL;
            s2_q    <= RST_VAL;
            prev_q  <= RST_VAL;
            prime_q <= 2'd0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign rise_o = (prime_q == 2'd3) &  s2_q & ~prev_q;
    assign fall_o = (prime_q == 2'd3) & ~s2_q &  prev_q;

endmodule

// File: rtl/amux_spi_ctrl.sv
// SPI-programmed analog-mux enables with break-before-make; commit 1 clk after 16th sck rise,
// BBM_CYCLES of all-zero before any new non-zero pattern. No backpressure: SPI is free-running.
module amux_spi_ctrl
    import amux_spi_pkg::*;
#(
    parameter int         NUM_CH     = 1,
    parameter int         BBM_CYCLES = 4,
    parameter logic [7:0] CHIP_ID    = CHIP_ID_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    amux_spi_ctrl_if.slave        spi,
    input  logic                  sel,
    input  logic                  amux_sel,
    input  logic [8*NUM_CH-1:0]   amux_pad_en,
    output logic [8*NUM_CH-1:0]   amux_en
);

    localparam int PW = 8 * NUM_CH;

    logic ss_rise, ss_fall, sck_rise, sck_fall;
    logic mosi_s1_q, mosi_s_q;

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst_n(rst_n), .d_i(spi.ss), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .d_i(spi.sck), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_s1_q <= 1'b0;
            mosi_s_q  <= 1'b0;
        end else begin
            mosi_s1_q <= spi.mosi;
            mosi_s_q  <= mosi_s1_q;
        end
    end

    frame_st_e           state_q, state_d;
    logic [3:0]          bit_cnt_q;
    logic [FRAME_W-1:0]  shift_q;
    logic                commit_q;
    logic                rd_q;
    logic [7:0]          rd_sh_q;
    logic                miso_q;
    logic [PW-1:0]       bank_q;

    logic                shift_en, cmd_end, frame_end, clr_cnt;
    logic [7:0]          cmd_byte;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          rd_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ss_fall) state_d = ST_CMD;
            ST_CMD: begin
                if (ss_rise)                             state_d = ST_IDLE;
                else if (sck_rise && bit_cnt_q == 4'd7)  state_d = ST_DATA;
            end
            ST_DATA: begin
                if (ss_rise)                             state_d = ST_IDLE;
                else if (sck_rise && bit_cnt_q == 4'd15) state_d = ST_DONE;
            end
            ST_DONE: if (ss_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        cmd_end   = 1'b0;
        frame_end = 1'b0;
        clr_cnt   = (state_q == ST_IDLE) || ss_rise;
        if ((state_q == ST_CMD || state_q == ST_DATA) && !ss_rise && sck_rise) begin
            shift_en  = 1'b1;
            cmd_end   = (state_q == ST_CMD)  && (bit_cnt_q == 4'd7);
            frame_end = (state_q == ST_DATA) && (bit_cnt_q == 4'd15);
        end
    end

    // The 8th command bit is still on mosi when the read data is latched.
    assign cmd_byte = {shift_q[6:0], mosi_s_q};
    assign cmd_addr = cmd_byte[ADDR_W-1:0];
    assign wr_addr  = shift_q[FRAME_W-2 -: ADDR_W];

    always_comb begin
        rd_dat = 8'h00;
        if (cmd_addr == ID_ADDR) begin
            rd_dat = CHIP_ID;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (cmd_addr == ADDR_W'(k)) begin
                rd_dat = bank_q[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
            commit_q  <= 1'b0;
        end else begin
            if (clr_cnt) begin
                bit_cnt_q <= 4'd0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (shift_en) begin
                shift_q <= {shift_q[FRAME_W-2:0], mosi_s_q};
            end
            commit_q <= frame_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= 1'b0;
            rd_sh_q <= 8'h00;
            miso_q  <= 1'b0;
        end else begin
            if (cmd_end) begin
                rd_q    <= cmd_byte[7];
                rd_sh_q <= rd_dat;
            end else if (state_q == ST_DATA && rd_q && sck_fall) begin
                rd_sh_q <= {rd_sh_q[6:0], 1'b0};
            end
            if (state_q != ST_DATA) begin
                miso_q <= 1'b0;
            end else if (rd_q && sck_fall) begin
                miso_q <= rd_sh_q[7];
            end
        end
    end

    assign spi.miso = miso_q;

    // shift_q is frozen in DONE, so it still holds the whole frame on the commit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else if (commit_q && !shift_q[FRAME_W-1]) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_addr == ADDR_W'(k)) begin
                    bank_q[8*k +: 8] <= shift_q[7:0];
                end
            end
        end
    end

    logic [PW-1:0] pat;
    logic [PW-1:0] p_last_q, p_last_d;
    logic [PW-1:0] en_q, en_d;
    logic          busy_q, busy_d;
    logic [7:0]    bbm_cnt_q, bbm_cnt_d;

    assign pat = !amux_sel ? '0 : (sel ? amux_pad_en : bank_q);

    always_comb begin
        p_last_d  = p_last_q;
        en_d      = en_q;
        busy_d    = busy_q;
        bbm_cnt_d = bbm_cnt_q;
        if (pat != p_last_q) begin
            p_last_d  = pat;
            en_d      = '0;
            busy_d    = (pat != '0);
            bbm_cnt_d = (pat != '0) ? 8'd1 : 8'd0;
        end else if (busy_q) begin
            if (bbm_cnt_q >= 8'(BBM_CYCLES)) begin
                en_d      = p_last_q;
                busy_d    = 1'b0;
                bbm_cnt_d = 8'd0;
            end else if (bbm_cnt_q != 8'hFF) begin
                bbm_cnt_d = bbm_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_last_q  <= '0;
            en_q      <= '0;
            busy_q    <= 1'b0;
            bbm_cnt_q <= 8'd0;
        end else begin
            p_last_q  <= p_last_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            bbm_cnt_q <= bbm_cnt_d;
        end
    end

    assign amux_en = en_q;

endmodule

// File: tb/tb_amux_spi_ctrl.sv
// Directed bench for amux_spi_ctrl with NUM_CH=2, BBM_CYCLES=4: SPI frames, readback,
// abort, BBM timing, source select and mid-frame reset, all against hand-computed values.
module tb_amux_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        amux_sel;
    logic [15:0] amux_pad_en;
    logic [15:0] amux_en;

    amux_spi_ctrl_if spi_if ();

    amux_spi_ctrl #(
        .NUM_CH     (2),
        .BBM_CYCLES (4),
        .CHIP_ID    (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (spi_if.slave),
        .sel         (sel),
        .amux_sel    (amux_sel),
        .amux_pad_en (amux_pad_en),
        .amux_en     (amux_en)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // sck half period 80 ns = 8 clk; miso sampled just before each rising sck.
    task automatic spi_xfer(input logic rw, input logic [6:0] addr, input logic [7:0] dat,
                            input int nbits, input bit close,
                            output logic [7:0] rdat, output logic cmd_miso);
        logic [15:0] fr;
        fr       = {rw, addr, dat};
        rdat     = 8'h00;
        cmd_miso = 1'b0;
        spi_if.ss = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            spi_if.mosi = fr[15-i];
            #80;
            if (i >= 8) rdat = {rdat[6:0], spi_if.miso};
            else        cmd_miso = cmd_miso | spi_if.miso;
            spi_if.sck = 1'b1;
            #80;
            spi_if.sck = 1'b0;
        end
        #80;
        if (close) begin
            spi_if.ss = 1'b1;
            #320;
        end
    endtask

    task automatic meas(input logic [15:0] tgt, input int budget, output int zeros, output bit hit);
        zeros = 0;
        hit   = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            if (amux_en == tgt)     hit = 1'b1;
            else if (amux_en == 0)  zeros++;
        end
    endtask

    logic [7:0] rd;
    logic       cm;
    int         z;
    bit         hit;
    int         other;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        spi_if.ss   = 1'b1;
        spi_if.sck  = 1'b0;
        spi_if.mosi = 1'b0;
        sel         = 1'b0;
        amux_sel    = 1'b1;
        amux_pad_en = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_en", 32'(amux_en), 32'h0);
        chk("reset_miso", 32'(spi_if.miso), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        spi_xfer(1'b0, 7'h00, 8'hB6, 16, 1'b1, rd, cm);
        chk("w0_miso_data", 32'(rd), 32'h0);
        chk("w0_miso_cmd", 32'(cm), 32'h0);
        meas(16'h00B6, 100, z, hit);
        chk("w0_en", 32'(amux_en), 32'h00B6);

        fork
            spi_xfer(1'b0, 7'h01, 8'h3C, 16, 1'b1, rd, cm);
            meas(16'h3CB6, 2000, z, hit);
        join
        chk("w1_hit", 32'(hit), 32'h1);
        chk("w1_bbm_zeros", 32'(z), 32'd4);

        spi_xfer(1'b1, 7'h7F, 8'h00, 16, 1'b1, rd, cm);
        chk("rd_id", 32'(rd), 32'hA5);
        chk("rd_id_cmd_miso", 32'(cm), 32'h0);
        spi_xfer(1'b1, 7'h05, 8'h00, 16, 1'b1, rd, cm);
        chk("rd_unmapped", 32'(rd), 32'h00);
        spi_xfer(1'b1, 7'h00, 8'h00, 16, 1'b1, rd, cm);
        chk("rd_bank0", 32'(rd), 32'hB6);
        spi_xfer(1'b1, 7'h01, 8'h00, 16, 1'b1, rd, cm);
        chk("rd_bank1", 32'(rd), 32'h3C);
        chk("en_after_reads", 32'(amux_en), 32'h3CB6);

        spi_xfer(1'b0, 7'h7F, 8'h00, 16, 1'b1, rd, cm);
        spi_xfer(1'b1, 7'h7F, 8'h00, 16, 1'b1, rd, cm);
        chk("id_write_ignored", 32'(rd), 32'hA5);
        spi_xfer(1'b0, 7'h05, 8'hFF, 16, 1'b1, rd, cm);
        chk("unmapped_write_ignored", 32'(amux_en), 32'h3CB6);

        // Abort after 11 bits: no commit, no enable activity.
        spi_xfer(1'b0, 7'h00, 8'h11, 11, 1'b1, rd, cm);
        other = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (amux_en != 16'h3CB6) other++;
        end
        chk("abort_en_stable", 32'(other), 32'h0);
        spi_xfer(1'b1, 7'h00, 8'h00, 16, 1'b1, rd, cm);
        chk("abort_bank0_kept", 32'(rd), 32'hB6);

        amux_pad_en = 16'h00FF;
        @(negedge clk);
        sel = 1'b1;
        meas(16'h00FF, 50, z, hit);
        chk("sel_pad_hit", 32'(hit), 32'h1);
        chk("sel_pad_zeros", 32'(z), 32'd4);
        amux_sel = 1'b0;
        @(negedge clk);
        chk("amux_sel_off_next", 32'(amux_en), 32'h0);

        amux_sel = 1'b1;
        meas(16'h00FF, 50, z, hit);
        chk("resel_hit", 32'(hit), 32'h1);

        // Two pattern changes two cycles apart: one restarted interval of 2+4 zeros.
        amux_pad_en = 16'h1234;
        z     = 0;
        other = 0;
        hit   = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (amux_en == 16'h5678) begin
                hit = 1'b1;
                break;
            end
            if (amux_en == 0) z++;
            else              other++;
            if (c == 1) amux_pad_en = 16'h5678;
        end
        chk("restart_hit", 32'(hit), 32'h1);
        chk("restart_zeros", 32'(z), 32'd6);
        chk("restart_no_stale", 32'(other), 32'h0);

        sel = 1'b0;
        meas(16'h3CB6, 50, z, hit);
        chk("back_to_banks", 32'(amux_en), 32'h3CB6);

        spi_xfer(1'b0, 7'h00, 8'h77, 12, 1'b0, rd, cm);
        rst_n = 1'b0;
        #30;
        chk("midreset_en", 32'(amux_en), 32'h0);
        chk("midreset_miso", 32'(spi_if.miso), 32'h0);
        rst_n = 1'b1;
        #100;
        spi_if.ss = 1'b1;
        #320;
        chk("post_reset_en", 32'(amux_en), 32'h0);
        spi_xfer(1'b1, 7'h00, 8'h00, 16, 1'b1, rd, cm);
        chk("post_reset_bank0", 32'(rd), 32'h00);
        spi_xfer(1'b0, 7'h00, 8'h5A, 16, 1'b1, rd, cm);
        meas(16'h005A, 100, z, hit);
        chk("post_reset_write", 32'(amux_en), 32'h005A);
        spi_xfer(1'b1, 7'h00, 8'h00, 16, 1'b1, rd, cm);
        chk("post_reset_readback", 32'(rd), 32'h5A);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/amux_spi_ctrl.md
AMUX_SPI_CTRL -- requirements
Module: amux_spi_ctrl

Interface
- REQ-001: Parameter NUM_CH, default 1: number of 8-bit analog-mux enable banks; legal range 1..8.
- REQ-002: Parameter BBM_CYCLES, default 4: break-before-make interval in clk cycles; legal range 1..255.
- REQ-003: Parameter CHIP_ID, default 8'hA5: value returned by the ID register.
- REQ-004: clk  in  1  system clock; frequency SHALL be at least 8x the sck frequency.
- REQ-005: rst_n  in  1  reset, asynchronous and active-low.
- REQ-006: ss  in  1  SPI slave select, active-low, asynchronous to clk.
- REQ-007: sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- REQ-008: mosi  in  1  SPI data in, MSB first.
- REQ-009: miso  out  1  SPI data out, MSB first.
- REQ-010: sel  in  1  source select: 0 = SPI registers, 1 = amux_pad_en pads.
- REQ-011: amux_sel  in  1  global enable; 0 forces amux_en to all zeros.
- REQ-012: amux_pad_en  in  8*NUM_CH  direct pad-driven enable pattern.
- REQ-013: amux_en  out  8*NUM_CH  analog switch enables; bank k occupies bits [8k+7:8k].

Function
- REQ-014: ss, sck and mosi SHALL pass through 2-FF synchronisers; sck rising and falling edges SHALL be detected in the clk domain.
- REQ-015: A frame SHALL be 16 bits: bit15 R/W (1 = read), bits14:8 address, bits7:0 data.
- REQ-016: Frame FSM states SHALL be IDLE, CMD (bits 15..8), DATA (bits 7..0) and DONE; synchronised ss falling moves IDLE->CMD; the 8th sck rise moves CMD->DATA; the 16th sck rise moves DATA->DONE; DONE->IDLE on ss rising.
- REQ-017: Synchronised ss rising in CMD or DATA SHALL abort the frame: no register write, FSM returns to IDLE, and the bit counter is cleared.
- REQ-018: Addresses 0..NUM_CH-1 SHALL be read/write bank registers; address 7'h7F SHALL be read-only CHIP_ID; any other address SHALL read 8'h00, and writes to it SHALL be ignored.
- REQ-019: A write SHALL commit to its bank register exactly one clk cycle after the 16th sck rising edge is detected.
- REQ-020: Writes to 7'h7F SHALL be ignored.
- REQ-021: For a read, the data SHALL be latched when the CMD->DATA transition occurs; each bit is driven on miso one clk after the detected sck falling edge, bit7 first.
- REQ-022: miso SHALL be 0 in IDLE, in CMD, and during write frames.
- REQ-023: Extra sck edges in DONE SHALL be ignored.
- REQ-024: The selected pattern P SHALL be: all zeros if amux_sel=0; otherwise amux_pad_en if sel=1; otherwise the concatenated bank registers.
- REQ-025: When P changes and the new P is non-zero, amux_en SHALL go to all zeros for exactly BBM_CYCLES clk cycles, then take the new P; a change to all zeros SHALL apply next cycle without delay.
- REQ-026: A further change of P during a BBM interval SHALL restart the interval; the value applied at its end SHALL be the latest P.
- REQ-027: The BBM counter SHALL saturate and SHALL NOT wrap.

Reset
- REQ-028: While rst_n=0: bank registers = 0, amux_en = 0, miso = 0, FSM = IDLE, bit counter = 0, BBM counter = 0, synchronisers = idle levels (ss=1, sck=0).
- REQ-029: Reset assertion mid-frame SHALL discard the frame.
- REQ-030: After reset release, the first frame SHALL require a fresh ss falling edge.

Structure
- REQ-031: Package amux_spi_pkg SHALL hold FRAME_W=16, ADDR_W=7, ID_ADDR=7'h7F, the FSM state enum and the default CHIP_ID.
- REQ-032: Sub-module spi_sync_edge (2-FF synchroniser plus rise/fall pulse) SHALL be instantiated once each for ss and sck; mosi SHALL use only its synchroniser.

Verification
- REQ-033: NUM_CH=2, write 0x00<-0xB6, then 0x01<-0x3C, with sel=0 and amux_sel=1 -> amux_en zero for 4 cycles after each commit, final value 16'h3CB6.
- REQ-034: Read address 0x7F -> miso shifts 8'hA5; read address 0x05 -> miso shifts 8'h00; bank registers unchanged.
- REQ-035: ss raised after 11 bits of a write to 0x00 -> register 0 retains its prior value and amux_en does not change.
- REQ-036: sel 0->1 with amux_pad_en=16'h00FF -> amux_en 0 for BBM_CYCLES, then 16'h00FF; then amux_sel=0 -> amux_en 0 on the next cycle.
- REQ-037: rst_n pulsed low during the DATA phase of a write -> all outputs 0, and the next full write frame commits correctly.
- REQ-038: Two writes with distinct values committed 2 cycles apart -> a single BBM interval, restarted at the second write, ending with the second value.
